// File: rtl/ps2_receptor.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the raw line, deserializes
// 11-bit frames and presents each valid scan code on ps2_Rx with a one-cycle rx_done.
module ps2_receptor #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic       Clk_F,
  input  logic       Reset_F,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_Rx,
  output logic       rx_done,
  output logic       frame_err
);

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  fclk_q, fclk_d;
  logic                  fall_edge;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [15:0]           tmo_q, tmo_d;
  logic                  timeout;
  logic                  frame_ok;
  logic [7:0]            rx_q, rx_d;
  logic                  rx_done_q, rx_done_d;
  logic                  frame_err_q, frame_err_d;

  // Clock-line filter: fclk only follows a level seen on FILTER_LEN consecutive samples.
  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], clk_s2_q};
    fclk_d = fclk_q;
    if (hist_q == '0) begin
      fclk_d = 1'b0;
    end else if (&hist_q) begin
      fclk_d = 1'b1;
    end
    fall_edge = fclk_q & ~fclk_d;
  end

  always_ff @(posedge Clk_F or negedge Reset_F) begin
    if (!Reset_F) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      hist_q   <= '1;
      fclk_q   <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      hist_q   <= hist_d;
      fclk_q   <= fclk_d;
    end
  end

  assign timeout = (state_q != StIdle) && (tmo_q == TmoLast);

  // State register
  always_ff @(posedge Clk_F or negedge Reset_F) begin
    if (!Reset_F) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a falling edge in the same cycle as a timeout takes priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fall_edge && !dat_s2_q) state_d = StData;
      StData:   if (fall_edge && bit_cnt_q == 3'd7) state_d = StParity;
      StParity: if (fall_edge) state_d = StStop;
      StStop:   if (fall_edge) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (timeout && !fall_edge) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = (state_q == StIdle || fall_edge) ? 16'd0 : tmo_q + 16'd1;
    if (fall_edge) begin
      unique case (state_q)
        StIdle: begin
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end
        StData: begin
          shift_d[bit_cnt_q] = dat_s2_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
        end
        StParity: parity_d = dat_s2_q;
        default: ;
      endcase
    end
  end

  // Output logic: stop bit must be 1 and data plus parity must have odd weight.
  always_comb begin
    frame_ok    = dat_s2_q & (^{shift_q, parity_q});
    rx_done_d   = (state_q == StStop) && fall_edge && frame_ok;
    frame_err_d = ((state_q == StStop) && fall_edge && !frame_ok) || (timeout && !fall_edge);
    rx_d        = rx_done_d ? shift_q : rx_q;
  end

  always_ff @(posedge Clk_F or negedge Reset_F) begin
    if (!Reset_F) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      tmo_q       <= 16'd0;
      rx_q        <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      rx_q        <= rx_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ps2_Rx    = rx_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_receptor.md
# ps2_receptor

- Upstream stage of the scan-code filter.
- Deserializes the raw PS/2 keyboard line (ps2_clk, ps2_data) into 8-bit scan codes.
- Presents each validated byte on ps2_Rx, which the filter consumes directly, with a one-cycle rx_done strobe.
- Includes input synchronization, clock-line glitch filtering, odd-parity and stop-bit checking, and an inter-bit timeout that recovers from truncated frames.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical synchronized ps2_clk samples required before the filtered clock changes level (2..16).
- TIMEOUT_CYC, 20000: Clk_F cycles without a falling edge, mid-frame, before the frame is abandoned (200 µs at 100 MHz; max 65535).

Ports:
- Clk_F  input  1  system clock, 100 MHz.
- Reset_F  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock from pin (asynchronous).
- ps2_data  input  1  raw PS/2 data from pin (asynchronous).
- ps2_Rx  output  8  last valid received byte; holds its value between frames.
- rx_done  output  1  one-cycle pulse when ps2_Rx is updated.
- frame_err  output  1  one-cycle pulse on parity error, bad stop bit or timeout.

## Operation
Input conditioning:
- ps2_clk and ps2_data each pass through a 2-flop synchronizer.
- Filtered clock fclk resets to 1. It takes the synchronized clock value once the last FILTER_LEN samples all equal it; otherwise it holds.
- fall_edge is asserted for one cycle when fclk goes 1→0. Data is sampled from synchronized ps2_data in that cycle.

Frame format: start (0), D0..D7 LSB first, odd parity, stop (1) — 11 bits.

State machine (states IDLE, DATA, PARITY, STOP):
- IDLE: on fall_edge with data=0 → DATA, bit counter=0, shift register cleared. On fall_edge with data=1: stay in IDLE, no error.
- DATA: each fall_edge shifts data into bit[cnt]. After the 8th bit → PARITY.
- PARITY: on fall_edge, store the parity bit → STOP.
- STOP: on fall_edge:
  - If stop=1 and XOR(D7..D0, parity)=1: load ps2_Rx, pulse rx_done.
  - Otherwise pulse frame_err and leave ps2_Rx unchanged.
  - In both cases → IDLE.
- Timeout counter:
  - Cleared on every fall_edge and whenever the FSM is in IDLE.
  - Increments in DATA/PARITY/STOP.
  - Reaching TIMEOUT_CYC → pulse frame_err, → IDLE, discard partial byte.
- Timeout and fall_edge in the same cycle: fall_edge wins and the counter clears.
- rx_done and frame_err are never asserted together.
- Host-to-device transmission is not supported; the block is receive-only.

Reset (Reset_F=0, at any time, including mid-frame):
- State → IDLE; counters, shift register and fclk return to their reset values.
- ps2_Rx=8'h00, rx_done=0, frame_err=0.
- Synchronizer flops reset to 1.
- After release, the partial frame in progress is not recovered. The next start bit is accepted.

## Timing
- ps2_clk pin fall to fall_edge: 2 (sync) + FILTER_LEN cycles, i.e. 10 cycles at default.
- ps2_data must be stable across that window; this holds by PS/2 protocol, since data is stable ~5 µs before the clock falls.
- rx_done and the new ps2_Rx value appear together, registered, 1 cycle after the fall_edge of the stop bit.
- ps2_Rx is stable until the next valid frame. Downstream may sample ps2_Rx on rx_done or continuously.
- A glitch on ps2_clk shorter than FILTER_LEN cycles produces no edge.
- Minimum PS/2 half-period accepted: FILTER_LEN+2 cycles. This is far below the spec minimum of 30 µs.

## Test plan
- Reset: hold Reset_F=0 for 100 ns → ps2_Rx=00, rx_done=0, frame_err=0. Release, then send frame 0x1C (parity 0, stop 1) at 12.5 kHz → exactly one rx_done pulse, ps2_Rx=1C, latency 11 cycles from the stop-bit pin fall.
- Break sequence: send frames F0 (parity 1), then 1C → two rx_done pulses; ps2_Rx=F0, then 1C; no frame_err.
- Parity error: send 0x1C with parity bit 1 → one frame_err pulse, no rx_done, ps2_Rx keeps its previous value. Then send 0x32 (parity 0) → ps2_Rx=32.
- Timeout: with TIMEOUT_CYC=500, send start bit plus 4 data bits, then idle ps2_clk high → frame_err 500 cycles after the last edge. Then send full frame 0x1C → ps2_Rx=1C.
- Glitch and mid-frame reset:
  - 5-cycle low pulse on ps2_clk while idle → no state change.
  - Assert Reset_F after 6 bits of frame 0xC4 → ps2_Rx=00 immediately.
  - Release, then send 0xC1 → ps2_Rx=C1, single rx_done.
